// File: rtl/pps_pkg.sv
// Shared definitions for the PPS divider control path: register map, FSM encoding,
// configuration record and reset defaults.
package pps_pkg;

  localparam logic [1:0] ADDR_PERIODIC = 2'd0;
  localparam logic [1:0] ADDR_DIV      = 2'd1;
  localparam logic [1:0] ADDR_PHASE    = 2'd2;
  localparam logic [1:0] ADDR_WIDTH    = 2'd3;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_CHECK    = 2'd1,
    ST_WAIT_PPS = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0]  periodic;
    logic [7:0]  div_number;
    logic [31:0] phase_us;
    logic [7:0]  width_us;
  } cfg_t;

  localparam logic [7:0]  RST_PERIODIC = 8'd1;
  localparam logic [7:0]  RST_DIV      = 8'd1;
  localparam logic [31:0] RST_PHASE    = 32'd0;

  function automatic cfg_t cfg_default(input logic [7:0] width);
    cfg_t c;
    c.periodic   = RST_PERIODIC;
    c.div_number = RST_DIV;
    c.phase_us   = RST_PHASE;
    c.width_us   = width;
    return c;
  endfunction

  // A zero divider or zero pulse width would wedge the divider, so both are rejected.
  function automatic logic cfg_valid(input cfg_t c);
    return (c.div_number != 8'd0) && (c.width_us != 8'd0);
  endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// one-cycle rising-edge pulse (pulse visible two edges after the first sampling flop).
module pps_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic rise_q,  rise_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/pps_divider_ctrl.sv
// Configuration sequencer for pps_divider: shadow registers, validation, and a
// PPS-aligned load of the live settings. All outputs are registered.
module pps_divider_ctrl
  import pps_pkg::*;
#(
  parameter logic [23:0] PPS_TIMEOUT_CYCLES = 24'd12_000_000,
  parameter logic [7:0]  DEFAULT_WIDTH_US   = 8'd20
) (
  input  logic        i_clk_10,
  input  logic        i_rst,
  input  logic        i_pps_raw,
  input  logic        i_wr_en,
  input  logic [1:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_commit,
  input  logic        i_halt,
  output logic [7:0]  o_periodic_true,
  output logic [7:0]  o_div_number,
  output logic [31:0] o_phase_us,
  output logic [7:0]  o_width_us,
  output logic [7:0]  o_start,
  output logic [7:0]  o_stop,
  output logic        o_busy,
  output logic        o_wr_reject,
  output logic        o_cfg_err,
  output logic        o_timeout
);

  state_t      state_q, state_d;
  cfg_t        shadow_q, shadow_d;
  cfg_t        live_q, live_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  start_q, start_d;
  logic [7:0]  stop_q, stop_d;
  logic        busy_q, busy_d;
  logic        reject_q, reject_d;
  logic        cfg_err_q, cfg_err_d;
  logic        timeout_q, timeout_d;
  logic        pps_rise;
  logic        busy_now;
  logic        commit_ok;
  logic        pps_expired;

  pps_sync_edge u_pps_sync (
    .clk      (i_clk_10),
    .rst      (i_rst),
    .async_in (i_pps_raw),
    .rise     (pps_rise)
  );

  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) state_q <= ST_HALTED;
    else       state_q <= state_d;
  end

  always_comb begin
    busy_now    = (state_q == ST_CHECK) || (state_q == ST_WAIT_PPS);
    commit_ok   = i_commit && !busy_now;
    pps_expired = (cnt_q == PPS_TIMEOUT_CYCLES - 24'd1);
    state_d     = state_q;
    case (state_q)
      ST_HALTED, ST_RUN: if (i_commit) state_d = ST_CHECK;
      ST_CHECK:          state_d = cfg_valid(shadow_q) ? ST_WAIT_PPS : ST_HALTED;
      ST_WAIT_PPS: begin
        if (pps_rise)         state_d = ST_RUN;
        else if (pps_expired) state_d = ST_HALTED;
      end
      default:           state_d = ST_HALTED;
    endcase
    if (i_halt) state_d = ST_HALTED;
  end

  // Outputs are computed from the next state so they line up with the state register.
  always_comb begin
    start_d = (state_d == ST_RUN) ? 8'd1 : 8'd0;
    stop_d  = (state_d == ST_RUN) ? 8'd0 : 8'd1;
    busy_d  = (state_d == ST_CHECK) || (state_d == ST_WAIT_PPS);
  end

  always_comb begin
    shadow_d = shadow_q;
    if (i_wr_en && !busy_now) begin
      case (i_wr_addr)
        ADDR_PERIODIC: shadow_d.periodic   = i_wr_data[7:0];
        ADDR_DIV:      shadow_d.div_number = i_wr_data[7:0];
        ADDR_PHASE:    shadow_d.phase_us   = i_wr_data;
        default:       shadow_d.width_us   = i_wr_data[7:0];
      endcase
    end
    live_d = ((state_q == ST_WAIT_PPS) && (state_d == ST_RUN)) ? shadow_q : live_q;
    cnt_d  = (state_q == ST_WAIT_PPS) ? cnt_q + 24'd1 : 24'd0;

    reject_d  = (i_wr_en || i_commit) && busy_now;
    cfg_err_d = cfg_err_q;
    timeout_d = timeout_q;
    if (commit_ok && !i_halt) begin
      cfg_err_d = 1'b0;
      timeout_d = 1'b0;
    end
    if ((state_q == ST_CHECK) && !cfg_valid(shadow_q)) cfg_err_d = 1'b1;
    if ((state_q == ST_WAIT_PPS) && !pps_rise && pps_expired && !i_halt) timeout_d = 1'b1;
  end

  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      shadow_q  <= cfg_default(DEFAULT_WIDTH_US);
      live_q    <= cfg_default(DEFAULT_WIDTH_US);
      cnt_q     <= 24'd0;
      start_q   <= 8'd0;
      stop_q    <= 8'd1;
      busy_q    <= 1'b0;
      reject_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      busy_q    <= busy_d;
      reject_q  <= reject_d;
      cfg_err_q <= cfg_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_periodic_true = live_q.periodic;
  assign o_div_number    = live_q.div_number;
  assign o_phase_us      = live_q.phase_us;
  assign o_width_us      = live_q.width_us;
  assign o_start         = start_q;
  assign o_stop          = stop_q;
  assign o_busy          = busy_q;
  assign o_wr_reject     = reject_q;
  assign o_cfg_err       = cfg_err_q;
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_pps_divider_ctrl.sv
// Directed bench for pps_divider_ctrl: stimulus pushes expected output snapshots
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_pps_divider_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pps = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic        commit = 1'b0;
  logic        halt = 1'b0;

  logic [7:0]  o_periodic_true, o_div_number, o_width_us, o_start, o_stop;
  logic [31:0] o_phase_us;
  logic        o_busy, o_wr_reject, o_cfg_err, o_timeout;

  always #5 clk = ~clk;

  pps_divider_ctrl #(
    .PPS_TIMEOUT_CYCLES (24'd2000),
    .DEFAULT_WIDTH_US   (8'd20)
  ) dut (
    .i_clk_10        (clk),
    .i_rst           (rst),
    .i_pps_raw       (pps),
    .i_wr_en         (wr_en),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .i_commit        (commit),
    .i_halt          (halt),
    .o_periodic_true (o_periodic_true),
    .o_div_number    (o_div_number),
    .o_phase_us      (o_phase_us),
    .o_width_us      (o_width_us),
    .o_start         (o_start),
    .o_stop          (o_stop),
    .o_busy          (o_busy),
    .o_wr_reject     (o_wr_reject),
    .o_cfg_err       (o_cfg_err),
    .o_timeout       (o_timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [75:0] v;
    logic [95:0] name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Hand-maintained expectation of every output
  logic [7:0]  m_per, m_div, m_w, m_start, m_stop;
  logic [31:0] m_ph;
  logic        m_busy, m_rej, m_cerr, m_tout;

  task automatic model_reset();
    m_per = 8'd1; m_div = 8'd1; m_ph = 32'd0; m_w = 8'd20;
    m_start = 8'd0; m_stop = 8'd1;
    m_busy = 1'b0; m_rej = 1'b0; m_cerr = 1'b0; m_tout = 1'b0;
  endtask

  task automatic push(input int at, input logic [95:0] nm);
    exp_t e;
    e.at   = at;
    e.v    = {m_start, m_stop, m_per, m_div, m_ph, m_w, m_busy, m_rej, m_cerr, m_tout};
    e.name = nm;
    q.push_back(e);
  endtask

  wire [75:0] act = {o_start, o_stop, o_periodic_true, o_div_number, o_phase_us,
                     o_width_us, o_busy, o_wr_reject, o_cfg_err, o_timeout};

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (e.at != cyc || act !== e.v) begin
        n_bad++;
        $display("FAIL %s cyc=%0d (due %0d) got=%h want=%h", e.name, cyc, e.at, act, e.v);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  initial begin
    int c;
    int c2;
    model_reset();
    tick(3);
    rst = 1'b0;
    c = cyc;
    push(c + 1, "reset");
    push(c + 3, "reset_idle");
    tick(4);

    // Shadow writes while halted: live outputs must not move
    wr(2'd0, 32'd3);
    wr(2'd1, 32'd4);
    wr(2'd3, 32'd50);
    wr(2'd2, 32'd10);
    push(cyc + 1, "no_live_chg");
    tick(2);

    c = cyc;
    m_busy = 1'b1;
    push(c + 1, "check_busy");
    push(c + 2, "wait_busy");
    commit = 1'b1; tick(1); commit = 1'b0;
    tick(5);

    // Write then commit while waiting for PPS: both rejected
    c = cyc;
    m_rej = 1'b1; push(c + 1, "rej_wr");
    m_rej = 1'b0; push(c + 2, "rej_clr");
    m_rej = 1'b1; push(c + 3, "rej_commit");
    m_rej = 1'b0; push(c + 4, "rej_clr2");
    wr(2'd1, 32'd9);
    tick(1);
    commit = 1'b1; tick(1); commit = 1'b0;
    tick(3);

    // PPS rises: load lands three edges after the first sampling edge
    c = cyc;
    push(c + 3, "pre_load");
    m_per = 8'd3; m_div = 8'd4; m_ph = 32'd10; m_w = 8'd50;
    m_start = 8'd1; m_stop = 8'd0; m_busy = 1'b0;
    push(c + 4, "load");
    push(c + 5, "run_hold");
    pps = 1'b1;
    tick(8);

    // div 0 written in RUN, then committed: cfg_err, live kept
    c = cyc;
    push(c + 1, "wr_in_run");
    m_start = 8'd0; m_stop = 8'd1; m_busy = 1'b1;
    push(c + 2, "inv_check");
    m_busy = 1'b0; m_cerr = 1'b1;
    push(c + 3, "cfg_err");
    push(c + 4, "cfg_err_hold");
    wr(2'd1, 32'd0);
    commit = 1'b1; tick(1); commit = 1'b0;
    tick(4);

    pps = 1'b0;
    tick(6);

    // Write and commit together: commit sees the new div, clears cfg_err
    c = cyc;
    m_cerr = 1'b0; m_busy = 1'b1;
    push(c + 1, "commit_clr");
    push(c + 2, "wait_new_div");
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'd2; commit = 1'b1;
    tick(1);
    wr_en = 1'b0; commit = 1'b0;
    tick(3);

    // Halt coincides with the detected PPS edge: no load
    c2 = cyc;
    push(c2 + 3, "pre_halt");
    m_busy = 1'b0;
    push(c2 + 4, "halt_on_pps");
    push(c2 + 6, "no_load");
    pps = 1'b1;
    tick(3);
    halt = 1'b1; tick(1); halt = 1'b0;
    tick(4);

    pps = 1'b0;
    tick(6);

    // PPS never comes: timeout after 2000 cycles in WAIT_PPS
    c = cyc;
    m_busy = 1'b1;
    push(c + 1, "tout_check");
    push(c + 2001, "pre_tout");
    m_busy = 1'b0; m_tout = 1'b1;
    push(c + 2002, "timeout");
    push(c + 2004, "tout_sticky");
    commit = 1'b1; tick(1); commit = 1'b0;
    tick(2008);

    // Reset mid-WAIT_PPS discards the pending commit
    c = cyc;
    m_tout = 1'b0; m_busy = 1'b1;
    push(c + 2, "wait2");
    commit = 1'b1; tick(1); commit = 1'b0;
    tick(3);
    rst = 1'b1;
    model_reset();
    push(cyc, "async_rst");
    tick(1);
    rst = 1'b0;
    pps = 1'b1;
    push(cyc + 6, "no_load_rst");
    tick(8);

    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
